// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to include the divider; otherwise only MULT/MULTU are accepted.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning: IDLE wait | PREP magnitudes+signs | RUN one bit/cycle | FIX sign fix, writeback
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q, b_q, opnd, acc_hi, acc_lo;
    logic               sgn_q, neg_q;
    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        mag = (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign prod    = {acc_hi, acc_lo};

`ifdef MULDIV_DIV_EN
    logic             div_q, rem_neg, b_zero;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    assign accept    = start;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    // true difference is below the divisor, so the low WIDTH bits are exact
    assign div_rem   = div_shift[WIDTH-1:0] - opnd;
`else
    assign accept    = start & ~op[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            sgn_q  <= 1'b0;
            neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
            rem_neg <= 1'b0;
            b_zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= PREP;
                        busy  <= 1'b1;
                        a_q   <= A;
                        b_q   <= B;
                        sgn_q <= ~op[0];
`ifdef MULDIV_DIV_EN
                        div_q <= op[1];
`endif
                    end else if (!start) begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                PREP: begin
                    state  <= RUN;
                    cnt    <= '0;
                    acc_hi <= '0;
                    neg_q  <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                    rem_neg <= sgn_q & a_q[WIDTH-1];
                    b_zero  <= (b_q == '0);
                    if (div_q) begin
                        opnd   <= mag(b_q, sgn_q);
                        acc_lo <= mag(a_q, sgn_q);
                    end else
`endif
                    begin
                        opnd   <= mag(a_q, sgn_q);
                        acc_lo <= mag(b_q, sgn_q);
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
`ifdef MULDIV_DIV_EN
                    if (div_q) begin
                        if (div_ge) begin
                            acc_hi <= div_rem;
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef MULDIV_DIV_EN
                    if (div_q) begin
                        if (b_zero) begin
                            hi <= a_q;
                            lo <= '1;
                        end else begin
                            hi <= rem_neg ? -acc_hi : acc_hi;
                            lo <= neg_q ? -acc_lo : acc_lo;
                        end
                    end else
`endif
                    begin
                        {hi, lo} <= neg_q ? -prod : prod;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; divide vectors run only when MULDIV_DIV_EN is defined.
module tb_muldiv_unit;

    logic        clk, rst_n, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a_s, b_s, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a_s), .B(b_s),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge; the return point is the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit disturb);
        logic [31:0] h0, l0;
        int          bcnt;
        bit          early;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op = o; a_s = a; b_s = b;
        @(negedge clk);
        start = 1'b0; op = 2'b00; a_s = 32'h5A5A5A5A; b_s = 32'hA5A5A5A5;
        chk({tag, ":done_single"}, done, 0);
        bcnt = 0;
        early = 1'b0;
        for (int k = 0; k < 34; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) bcnt++;
            if (done) early = 1'b1;
            if (disturb && k == 12) begin
                start = 1'b1; op = 2'b01; a_s = 32'd1; b_s = 32'd1;
                mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
            end
            if (disturb && k == 13) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
        end
        chk({tag, ":hold_hi"}, hi, h0);
        chk({tag, ":hold_lo"}, lo, l0);
        chk({tag, ":busy_cycles"}, bcnt, 34);
        chk({tag, ":early_done"}, early, 0);
        @(negedge clk);
        chk({tag, ":done"}, done, 1);
        chk({tag, ":busy_end"}, busy, 0);
        chk({tag, ":hi"}, hi, eh);
        chk({tag, ":lo"}, lo, el);
    endtask

    initial begin
        bit any_busy, any_done;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a_s = '0; b_s = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
        run_op("mult_negneg", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h6, 1'b0);
        run_op("multu_msb", 2'b01, 32'h80000000, 32'd2, 32'h1, 32'h0, 1'b0);
`ifdef MULDIV_DIV_EN
        run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_op("div_neg_by0", 2'b10, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
`endif

        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h00001234);
`ifdef MULDIV_DIV_EN
        chk("mthi_lo_kept", lo, 32'd14);
`else
        chk("mthi_lo_kept", lo, 32'h0);
`endif
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55AA;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo_hi", hi, 32'h55AA);
        chk("mthilo_lo", lo, 32'h55AA);

        start = 1'b1; op = 2'b01; a_s = 32'd3; b_s = 32'd3; mthi = 1'b1; wdata = 32'hBEEF;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        chk("start_prio_hi", hi, 32'h55AA);
        repeat (34) @(negedge clk);
        chk("start_prio_res_lo", lo, 32'd9);

`ifndef MULDIV_DIV_EN
        start = 1'b1; op = 2'b10; a_s = 32'd100; b_s = 32'd7;
        @(negedge clk);
        op = 2'b11;
        @(negedge clk);
        start = 1'b0;
        any_busy = 1'b0; any_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) any_busy = 1'b1;
            if (done) any_done = 1'b1;
            @(negedge clk);
        end
        chk("nodiv_busy", any_busy, 0);
        chk("nodiv_done", any_done, 0);
        chk("nodiv_hi", hi, 32'h0);
        chk("nodiv_lo", lo, 32'd9);
`endif

        start = 1'b1; op = 2'b01; a_s = 32'hFFFFFFFF; b_s = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("midop_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        chk("abort_no_done", any_done, 0);

        run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
